// File: rtl/seg_scan_driver_if.sv
// Bus between the score pipeline and the 4-digit 7-segment scan driver.
// The master side supplies BCD digits, a load strobe and a blank request.
// The slave side (the driver) returns the anode, cathode and dp drives
// plus the current scan index.
interface seg_scan_driver_if;
  logic [3:0] thous;
  logic [3:0] hund;
  logic [3:0] tens;
  logic [3:0] units;
  logic       load;
  logic       blank;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] digit_idx;

  modport master (
    output thous, hund, tens, units, load, blank,
    input  an, seg, dp, digit_idx
  );

  modport slave (
    input  thous, hund, tens, units, load, blank,
    output an, seg, dp, digit_idx
  );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for a 4-digit common-anode
// 7-segment display. A prescaler divides the clock into digit slots of
// REFRESH_DIV cycles. The first cycle of every slot is dead time with all
// anodes off, which suppresses ghosting. Anode and cathode drives are
// registered, so they lag the internal state by one cycle.
// Optional feature: define SEG_LZ_BLANK_EN to blank leading zeros.
module seg_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_driver_if.slave  bus
);

  localparam int                 CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [3:0]       r_dig [4];   // shadow digits, index 0 = units
  logic [3:0]       r_an;
  logic [6:0]       r_seg;

  logic             w_wrap;
  logic [3:0]       w_cur_dig;
  logic             w_supp;
  logic [3:0]       w_an_nxt;
  logic [6:0]       w_seg_nxt;

  // BCD to active-low {g,f,e,d,c,b,a}; anything above 9 shows a dash
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign w_wrap = (r_cnt == CNT_LAST);

  // Select the digit for the current slot and decide the next anode/cathode drive
  always_comb begin
    w_cur_dig = r_dig[r_idx];
    w_supp    = 1'b0;
`ifdef SEG_LZ_BLANK_EN
    // A digit is a leading zero when it and every more significant digit are 0
    case (r_idx)
      2'd3:    w_supp = (r_dig[3] == 4'd0);
      2'd2:    w_supp = (r_dig[3] == 4'd0) && (r_dig[2] == 4'd0);
      2'd1:    w_supp = (r_dig[3] == 4'd0) && (r_dig[2] == 4'd0) && (r_dig[1] == 4'd0);
      default: w_supp = 1'b0;
    endcase
`endif
    w_an_nxt  = ((r_cnt == '0) || bus.blank) ? 4'b1111 : ~(4'b0001 << r_idx);
    w_seg_nxt = w_supp ? 7'h7F : bcd_to_seg(w_cur_dig);
  end

  // Prescaler and scan index; a load never disturbs the scan timing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Shadow digit registers; reset wins over a coincident load
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_dig[i] <= 4'd0;
    end else if (bus.load) begin
      r_dig[0] <= bus.units;
      r_dig[1] <= bus.tens;
      r_dig[2] <= bus.hund;
      r_dig[3] <= bus.thous;
    end
  end

  // Output registers: one cycle behind the scan state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= 4'b1111;
      r_seg <= 7'h7F;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign bus.an        = r_an;
  assign bus.seg       = r_seg;
  assign bus.dp        = 1'b1;
  assign bus.digit_idx = r_idx;

endmodule
